// File: rtl/parity_serializer.sv
// Parallel-to-serial framer: DATA_W payload bits LSB first, then one parity bit.
// Define PARITY_SER_ODD_EN to invert the parity bit (odd parity); default is even parity.
module parity_serializer #(
    parameter int unsigned DATA_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

`ifdef PARITY_SER_ODD_EN
    localparam logic ParInv = 1'b1;
`else
    localparam logic ParInv = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              accept;

    // Ready in PARITY lets back-to-back frames run with no idle gap.
    assign din_ready   = !rst && (state_q != StShift);
    assign accept      = din_valid && din_ready;
    assign busy        = (state_q != StIdle);
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        par_d         = par_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            StShift: begin
                // cnt_q counts payload bits already on the wire.
                if (cnt_q == CntW'(DATA_W)) begin
                    dout_d       = par_q ^ ParInv;
                    dout_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = StParity;
                end else begin
                    dout_d       = shift_q[0];
                    dout_valid_d = 1'b1;
                    par_d        = par_q ^ shift_q[0];
                    shift_d      = shift_q >> 1;
                    cnt_d        = cnt_q + CntW'(1);
                end
            end
            StIdle, StParity: begin
                if (accept) begin
                    shift_d       = din >> 1;
                    dout_d        = din[0];
                    dout_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                    par_d         = din[0];
                    cnt_d         = CntW'(1);
                    state_d       = StShift;
                end else begin
                    par_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            cnt_q         <= '0;
            par_q         <= 1'b0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer (DATA_W=15); honours PARITY_SER_ODD_EN.
module tb_parity_serializer;

`ifdef PARITY_SER_ODD_EN
    localparam logic ParInv = 1'b1;
`else
    localparam logic ParInv = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        dout;
    logic        dout_valid;
    logic        frame_start;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    parity_serializer #(.DATA_W(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called on a falling edge; the accept happens on the next rising edge.
    task automatic run_frame(input logic [14:0] w, input logic par_even, input logic hold,
                             input int abort_at, input logic disturb);
        din       = w;
        din_valid = 1'b1;
        #1;
        chk("ready_before_accept", din_ready, 1'b1);
        @(negedge clk);
        din_valid = hold;
        for (int i = 0; i < 15; i++) begin
            chk("data_bit", dout, w[i]);
            chk("data_valid", dout_valid, 1'b1);
            chk("frame_start", frame_start, (i == 0));
            chk("ready_in_shift", din_ready, 1'b0);
            chk("busy_in_shift", busy, 1'b1);
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_dout", dout, 1'b0);
                chk("abort_valid", dout_valid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_fs", frame_start, 1'b0);
                chk("abort_ready_in_rst", din_ready, 1'b0);
                rst       = 1'b0;
                din_valid = 1'b0;
                return;
            end
            if (disturb && i == 3) begin
                din       = ~w;
                din_valid = 1'b1;
            end
            if (disturb && i == 4) din_valid = hold;
            @(negedge clk);
        end
        chk("parity_bit", dout, par_even ^ ParInv);
        chk("parity_valid", dout_valid, 1'b1);
        chk("parity_fs", frame_start, 1'b0);
        chk("ready_in_parity", din_ready, 1'b1);
    endtask

    // Called on the falling edge of the parity cycle when no new word follows.
    task automatic idle_check();
        din_valid = 1'b0;
        @(negedge clk);
        chk("idle_dout", dout, 1'b0);
        chk("idle_valid", dout_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", din_ready, 1'b1);
        chk("idle_fs", frame_start, 1'b0);
    endtask

    initial begin
        // Reset with din_valid high: reset must win.
        rst       = 1'b1;
        din       = 15'h7FFF;
        din_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready", din_ready, 1'b0);
        chk("rst_dout", dout, 1'b0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", dout_valid, 1'b0);
        chk("post_rst_ready", din_ready, 1'b1);

        // Single bit set: parity 1.
        run_frame(15'h0001, 1'b1, 1'b0, -1, 1'b0);
        idle_check();

        // All ones (15 ones -> parity 1), then two ones back-to-back (parity 0).
        run_frame(15'h7FFF, 1'b1, 1'b0, -1, 1'b0);
        run_frame(15'h0003, 1'b0, 1'b0, -1, 1'b0);
        idle_check();

        // din_valid held high across two frames: 0x1234 has 5 ones, 0x5555 has 8 ones.
        run_frame(15'h1234, 1'b1, 1'b1, -1, 1'b0);
        run_frame(15'h5555, 1'b0, 1'b1, -1, 1'b0);
        idle_check();

        // Reset on the 6th bit, then a clean frame (0x4000 -> parity 1).
        run_frame(15'h2AAA, 1'b0, 1'b0, 5, 1'b0);
        run_frame(15'h4000, 1'b1, 1'b0, -1, 1'b0);
        idle_check();

        // din changed and din_valid pulsed mid-frame: 0x0F0F has 8 ones.
        run_frame(15'h0F0F, 1'b0, 1'b0, -1, 1'b1);
        idle_check();

        // All zeros -> parity 0 (inverted in the odd build).
        run_frame(15'h0000, 1'b0, 1'b0, -1, 1'b0);
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_serializer.md
# parity_serializer

Parallel-to-serial even-parity encoder that sits directly upstream of the serial parity decoder. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, followed by one parity bit. This produces a DATA_W+1-bit frame (16 bits at default). The decoder stores the frame by bit index and checks the final bit as parity.

## Interface
- DATA_W, 15, payload width per frame; legal range 1..255; frame length = DATA_W+1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- din  input  DATA_W  parallel payload word.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle; transfer occurs when din_valid && din_ready at a rising edge.
- dout  output  1  serial frame bit, registered.
- dout_valid  output  1  dout carries a frame bit this cycle, registered.
- frame_start  output  1  high with bit 0 of each frame, registered.
- busy  output  1  frame in progress (state != IDLE).

## Operation
- Reset values: dout=0, dout_valid=0, frame_start=0, busy=0, state=IDLE, bit counter=0, parity accumulator=0. din_ready=0 while rst is high.
- The shift register is DATA_W bits. The bit counter is $clog2(DATA_W+1) bits wide. The parity accumulator is 1 bit.
- FSM states: IDLE, SHIFT, PARITY.
  - IDLE: din_ready=1. On accept: load din into the shift register, drive dout=din[0], dout_valid=1, frame_start=1, parity=din[0], counter=1, and go to SHIFT. If DATA_W=1, go to PARITY instead.
  - SHIFT: din_ready=0. Each cycle: dout=next bit, parity ^= that bit, counter+1, frame_start=0. After the bit with index DATA_W-1 is driven, go to PARITY.
  - PARITY: dout=parity (XOR of all DATA_W payload bits), dout_valid=1. din_ready=1 in this state.
    - On accept, the next frame's bit 0 follows in the very next cycle with no gap, and the FSM goes to SHIFT (or PARITY if DATA_W=1).
    - Without accept, go to IDLE with dout_valid=0 and dout=0 on the following cycle.
- Even parity: XOR over all DATA_W+1 frame bits equals 0.
- Reset mid-frame: the frame is abandoned, no parity bit is emitted, and all outputs take their reset values on the next edge.
- din is sampled only at the accept edge. Later changes to din do not affect the frame in flight.
- din_valid in SHIFT is ignored (not accepted) and must be held by the source.

## Timing
- Accept at edge N: bit i appears on dout during cycle N+1+i for i=0..DATA_W-1. Parity appears during cycle N+1+DATA_W.
- Latency from accept to first bit: 1 cycle. Frame duration: DATA_W+1 cycles.
- Continuous throughput: one frame every DATA_W+1 cycles when din_valid stays high (accept occurs in the PARITY cycle).
- Idle accept: one cycle after the parity bit, din_ready is asserted in IDLE.
- rst and din_valid high in the same cycle: reset wins, nothing is accepted.

## Configuration
- PARITY_SER_ODD_EN:
  - Defined: the parity bit is inverted (odd parity; XOR over the full frame = 1).
  - Undefined (default): even parity as above.
  - Nothing else changes: latency, handshake and all other outputs are identical in both builds.

## Test plan
- Reset, then DATA_W=15, din=15'h0001 accepted at edge N -> dout over cycles N+1..N+16 = 1, fourteen 0s, parity 1. frame_start high only at N+1.
- din=15'h7FFF -> fifteen 1s then parity 1. din=15'h0003 -> 1,1, thirteen 0s, parity 0. The decoder downstream reports a match for both.
- din_valid held high with words 15'h1234 then 15'h5555 -> second frame bit 0 directly follows the first parity bit. dout_valid is never low between frames. Parities are 1 and 0.
- rst asserted at the 6th bit of a frame -> next cycle dout=0, dout_valid=0, busy=0, no parity emitted. After reset deasserts, din_ready=1 and a new frame sends correctly.
- din changed during SHIFT and din_valid pulsed in SHIFT -> serial output is unchanged and there is no extra accept.
- Build with PARITY_SER_ODD_EN, din=15'h0001 -> parity bit 0. din=15'h0000 -> parity bit 1.
